// File: rtl/vend_credit_fsm_pkg.sv
// vend_pkg: shared types and constants for the vend_credit_fsm block.
//   state_e     - controller states (IDLE, HOLD, DISPENSE, RETURN)
//   SEG0..SEG9  - active-low 7-segment patterns, bit order [0:6] = a..g
//   SEG_BLANK   - all segments off, shown for non-BCD inputs
//   coin_value  - value of coin index idx for a given smallest-coin value
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    DISPENSE = 2'd2,
    RETURN   = 2'd3
  } state_e;

  localparam logic [0:6] SEG0      = 7'b000_0001;
  localparam logic [0:6] SEG1      = 7'b100_1111;
  localparam logic [0:6] SEG2      = 7'b001_0010;
  localparam logic [0:6] SEG3      = 7'b000_0110;
  localparam logic [0:6] SEG4      = 7'b100_1100;
  localparam logic [0:6] SEG5      = 7'b010_0100;
  localparam logic [0:6] SEG6      = 7'b010_0000;
  localparam logic [0:6] SEG7      = 7'b000_1111;
  localparam logic [0:6] SEG8      = 7'b000_0000;
  localparam logic [0:6] SEG9      = 7'b000_0100;
  localparam logic [0:6] SEG_BLANK = 7'b111_1111;

  function automatic int unsigned coin_value(input int unsigned unit_val,
                                             input int unsigned idx);
    return unit_val * (idx + 1);
  endfunction

endpackage

// File: rtl/vend_credit_fsm_seg7.sv
// seg7_digit: BCD digit to active-low 7-segment pattern.
//   bcd_i  in  4      BCD digit 0..9 (other codes blank the digit)
//   seg_o  out [0:6]  segments a..g, active-low
module seg7_digit
  import vend_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [0:6] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG0;
      4'd1:    seg_o = SEG1;
      4'd2:    seg_o = SEG2;
      4'd3:    seg_o = SEG3;
      4'd4:    seg_o = SEG4;
      4'd5:    seg_o = SEG5;
      4'd6:    seg_o = SEG6;
      4'd7:    seg_o = SEG7;
      4'd8:    seg_o = SEG8;
      4'd9:    seg_o = SEG9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/vend_credit_fsm.sv
// vend_credit_fsm: coin-credit vending controller with decimal credit display.
// Optional feature macro: AUTO_VEND_EN (auto purchase + change once credit
// reaches PRICE after a coin; vend input ignored).
// Ports:
//   CLOCK_50      in   1         sole clock
//   RST_N         in   1         asynchronous active-low reset
//   coin          in   N_COIN    raw coin buttons, coin i worth UNIT*(i+1)
//   vend          in   1         raw purchase button
//   refund        in   1         raw refund button
//   clear         in   1         raw clear button (credit to 0, no change)
//   credit        out  CREDIT_W  current credit
//   dispense      out  1         one-cycle pulse, item released
//   deny          out  1         one-cycle pulse, vend with credit < PRICE
//   reject        out  1         one-cycle pulse, coin would exceed MAX_CREDIT
//   change        out  CREDIT_W  last returned change amount
//   change_valid  out  1         one-cycle pulse qualifying change
//   HEX2/HEX1/HEX0 out [0:6]     hundreds/tens/units, active-low a..g
module vend_credit_fsm
  import vend_pkg::*;
#(
  parameter int unsigned UNIT       = 4,
  parameter int unsigned N_COIN     = 3,
  parameter int unsigned CREDIT_W   = 8,
  parameter int unsigned MAX_CREDIT = 20,
  parameter int unsigned PRICE      = 16
) (
  input  logic                CLOCK_50,
  input  logic                RST_N,
  input  logic [N_COIN-1:0]   coin,
  input  logic                vend,
  input  logic                refund,
  input  logic                clear,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic                deny,
  output logic                reject,
  output logic [CREDIT_W-1:0] change,
  output logic                change_valid,
  output logic [0:6]          HEX2,
  output logic [0:6]          HEX1,
  output logic [0:6]          HEX0
);

  if ((longint'(MAX_CREDIT) >= (longint'(1) << CREDIT_W)) ||
      (MAX_CREDIT > 999) || (PRICE > MAX_CREDIT)) begin : g_bad_params
    $error("vend_credit_fsm: illegal parameter combination");
  end

  // Raw buttons packed as {clear, refund, vend, coin}.
  localparam int unsigned NB = N_COIN + 3;
  localparam logic [CREDIT_W:0]   MAX_W   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W:0]   PRICE_W = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  logic [NB-1:0] sync1_q, sync2_q, prev_q, rise;
  logic [1:0]    settle_q;

  // settle_q masks edges until the synchroniser and prev_q have been filled
  // from real input levels, so a button held through reset release is seen
  // as already high rather than as a fresh press.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      settle_q <= '0;
    end else begin
      sync1_q <= {clear, refund, vend, coin};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
    end
  end

  assign rise = sync2_q & ~prev_q & {NB{settle_q == 2'd3}};

  // A coin counts only if a single bit rose and no other coin bit is high.
  logic [N_COIN-1:0] coin_rise, coin_lvl;
  logic              coin_ok;
  logic [CREDIT_W:0] coin_val;
  assign coin_rise = rise[N_COIN-1:0];
  assign coin_lvl  = sync2_q[N_COIN-1:0];
  assign coin_ok   = $onehot(coin_rise) && (coin_lvl == coin_rise);

  always_comb begin
    coin_val = '0;
    for (int unsigned i = 0; i < N_COIN; i++) begin
      if (coin_rise[i]) coin_val = (CREDIT_W+1)'(coin_value(UNIT, i));
    end
  end

  // Registered edge events; this stage gives the three-edge input latency.
  logic              coin_evt_q, vend_evt_q, refund_evt_q, clear_evt_q;
  logic [CREDIT_W:0] coin_val_q;

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      coin_evt_q   <= 1'b0;
      coin_val_q   <= '0;
      vend_evt_q   <= 1'b0;
      refund_evt_q <= 1'b0;
      clear_evt_q  <= 1'b0;
    end else begin
      coin_evt_q   <= coin_ok;
      coin_val_q   <= coin_val;
      vend_evt_q   <= rise[N_COIN];
      refund_evt_q <= rise[N_COIN+1];
      clear_evt_q  <= rise[N_COIN+2];
    end
  end

  state_e              state_q;
  logic [CREDIT_W-1:0] credit_q, change_q;
  logic                dispense_q, deny_q, reject_q, change_valid_q;
  logic [CREDIT_W:0]   coin_sum_d;

  // One extra bit so the ceiling comparison cannot wrap.
  assign coin_sum_d = {1'b0, credit_q} + coin_val_q;

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      change_q       <= '0;
      dispense_q     <= 1'b0;
      deny_q         <= 1'b0;
      reject_q       <= 1'b0;
      change_valid_q <= 1'b0;
    end else begin
      dispense_q     <= 1'b0;
      deny_q         <= 1'b0;
      reject_q       <= 1'b0;
      change_valid_q <= 1'b0;
      case (state_q)
        // Credit was already reduced on entry; events here are dropped.
        DISPENSE: begin
`ifdef AUTO_VEND_EN
          state_q        <= RETURN;
          change_q       <= credit_q;
          change_valid_q <= 1'b1;
          credit_q       <= '0;
`else
          state_q <= (credit_q == '0) ? IDLE : HOLD;
`endif
        end
        RETURN: state_q <= IDLE;
        default: begin
          if (clear_evt_q) begin
            credit_q <= '0;
            state_q  <= IDLE;
          end else if (refund_evt_q) begin
            if (state_q == HOLD) begin
              state_q        <= RETURN;
              change_q       <= credit_q;
              change_valid_q <= 1'b1;
              credit_q       <= '0;
            end
`ifndef AUTO_VEND_EN
          end else if (vend_evt_q) begin
            if ({1'b0, credit_q} >= PRICE_W) begin
              state_q    <= DISPENSE;
              dispense_q <= 1'b1;
              credit_q   <= credit_q - PRICE_C;
            end else begin
              deny_q <= 1'b1;
            end
`endif
          end else if (coin_evt_q) begin
            if (coin_sum_d > MAX_W) begin
              reject_q <= 1'b1;
`ifdef AUTO_VEND_EN
            end else if (coin_sum_d >= PRICE_W) begin
              state_q    <= DISPENSE;
              dispense_q <= 1'b1;
              credit_q   <= CREDIT_W'(coin_sum_d - PRICE_W);
`endif
            end else begin
              credit_q <= CREDIT_W'(coin_sum_d);
              state_q  <= HOLD;
            end
          end
        end
      endcase
    end
  end

  assign credit       = credit_q;
  assign change       = change_q;
  assign dispense     = dispense_q;
  assign deny         = deny_q;
  assign reject       = reject_q;
  assign change_valid = change_valid_q;

  // Credit never exceeds 999, so 10 bits are enough for the BCD split.
  logic [9:0] disp_val;
  logic [3:0] digit_bcd [3];
  logic [0:6] digit_seg [3];

  assign disp_val     = 10'(credit_q);
  assign digit_bcd[2] = 4'(disp_val / 10'd100);
  assign digit_bcd[1] = 4'((disp_val / 10'd10) % 10'd10);
  assign digit_bcd[0] = 4'(disp_val % 10'd10);

  for (genvar gi = 0; gi < 3; gi++) begin : g_digit
    seg7_digit u_seg (
      .bcd_i (digit_bcd[gi]),
      .seg_o (digit_seg[gi])
    );
  end

  assign HEX2 = digit_seg[2];
  assign HEX1 = digit_seg[1];
  assign HEX0 = digit_seg[0];

endmodule

// File: tb/tb_vend_credit_fsm.sv
module tb_vend_credit_fsm;

  localparam int UNIT = 4, N_COIN = 3, CREDIT_W = 8, MAX_CREDIT = 20, PRICE = 16;
`ifdef AUTO_VEND_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic                CLOCK_50 = 1'b0;
  logic                RST_N;
  logic [N_COIN-1:0]   coin;
  logic                vend, refund, clear;
  logic [CREDIT_W-1:0] credit, change;
  logic                dispense, deny, reject, change_valid;
  logic [0:6]          HEX2, HEX1, HEX0;

  always #5 CLOCK_50 = ~CLOCK_50;

  vend_credit_fsm #(
    .UNIT(UNIT), .N_COIN(N_COIN), .CREDIT_W(CREDIT_W),
    .MAX_CREDIT(MAX_CREDIT), .PRICE(PRICE)
  ) dut (
    .CLOCK_50(CLOCK_50), .RST_N(RST_N), .coin(coin), .vend(vend),
    .refund(refund), .clear(clear), .credit(credit), .dispense(dispense),
    .deny(deny), .reject(reject), .change(change), .change_valid(change_valid),
    .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: credit and last returned change.
  int m_credit = 0;
  int m_change = 0;
  int e_disp, e_deny, e_rej, e_cv;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0000001;  1: return 7'b1001111;
      2: return 7'b0010010;  3: return 7'b0000110;
      4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;
      8: return 7'b0000000;  9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_display(input string tag);
    check({tag, "_credit"}, 32'(credit), 32'(m_credit));
    check({tag, "_hex2"}, 32'(HEX2), 32'(seg_of(m_credit / 100)));
    check({tag, "_hex1"}, 32'(HEX1), 32'(seg_of((m_credit / 10) % 10)));
    check({tag, "_hex0"}, 32'(HEX0), 32'(seg_of(m_credit % 10)));
  endtask

  // Behavioural rules: highest-priority pressed button decides the outcome.
  task automatic model_apply(input logic [N_COIN-1:0] cp, input logic v, input logic r, input logic c);
    int val;
    e_disp = 0; e_deny = 0; e_rej = 0; e_cv = 0;
    if (c) begin
      m_credit = 0;
    end else if (r) begin
      if (m_credit > 0) begin
        m_change = m_credit; e_cv = 1; m_credit = 0;
      end
    end else if (v && !AUTO) begin
      if (m_credit >= PRICE) begin
        e_disp = 1; m_credit -= PRICE;
      end else begin
        e_deny = 1;
      end
    end else if ($countones(cp) == 1) begin
      val = 0;
      for (int i = 0; i < N_COIN; i++) if (cp[i]) val = UNIT * (i + 1);
      if (m_credit + val > MAX_CREDIT) begin
        e_rej = 1;
      end else begin
        m_credit += val;
        if (AUTO && m_credit >= PRICE) begin
          e_disp = 1; e_cv = 1; m_change = m_credit - PRICE; m_credit = 0;
        end
      end
    end
  endtask

  // One transaction: press, watch 8 cycles of pulses, release, re-arm.
  task automatic txn(input string name, input logic [N_COIN-1:0] cp,
                     input logic v, input logic r, input logic c);
    int n_disp = 0, n_deny = 0, n_rej = 0, n_cv = 0, seen_change = -1;
    @(negedge CLOCK_50);
    coin = cp; vend = v; refund = r; clear = c;
    model_apply(cp, v, r, c);
    repeat (8) begin
      @(negedge CLOCK_50);
      n_disp += int'(dispense); n_deny += int'(deny);
      n_rej  += int'(reject);   n_cv   += int'(change_valid);
      if (change_valid) seen_change = int'(change);
    end
    coin = '0; vend = 1'b0; refund = 1'b0; clear = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    check({name, "_dispense"}, 32'(n_disp), 32'(e_disp));
    check({name, "_deny"}, 32'(n_deny), 32'(e_deny));
    check({name, "_reject"}, 32'(n_rej), 32'(e_rej));
    check({name, "_change_valid"}, 32'(n_cv), 32'(e_cv));
    check({name, "_change_pulse"}, 32'(seen_change), 32'(e_cv ? m_change : -1));
    check({name, "_change_hold"}, 32'(change), 32'(m_change));
    check_display(name);
    $display("txn %s: coin=%b vend=%0d refund=%0d clear=%0d -> credit=%0d change=%0d disp=%0d deny=%0d rej=%0d cv=%0d",
             name, cp, v, r, c, credit, change, n_disp, n_deny, n_rej, n_cv);
  endtask

  initial begin
    int n_rej, n_any;
    logic [N_COIN-1:0] cp;
    logic v, r, c;
    int kind;

    RST_N = 1'b0; coin = '0; vend = 1'b0; refund = 1'b0; clear = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("rst_dispense", 32'(dispense), 32'(0));
    check("rst_deny", 32'(deny), 32'(0));
    check("rst_reject", 32'(reject), 32'(0));
    check("rst_change_valid", 32'(change_valid), 32'(0));
    check("rst_change", 32'(change), 32'(0));
    check_display("rst");
    RST_N = 1'b1;
    repeat (4) @(negedge CLOCK_50);
    check_display("post_rst");
    $display("txn reset: credit=%0d", credit);

    // Latency: level sampled at edge n, credit updates at edge n+3.
    coin = 3'b001;
    model_apply(3'b001, 1'b0, 1'b0, 1'b0);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50); check("lat_edge_n", 32'(credit), 32'(0));
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50); check("lat_edge_n2", 32'(credit), 32'(0));
    @(posedge CLOCK_50);
    @(negedge CLOCK_50); check("lat_edge_n3", 32'(credit), 32'(4));
    coin = '0;
    repeat (4) @(negedge CLOCK_50);
    $display("txn latency: credit=%0d", credit);

    txn("coin12_to16", 3'b100, 1'b0, 1'b0, 1'b0);
    txn("vend16", 3'b000, 1'b1, 1'b0, 1'b0);
    txn("clear_a", 3'b000, 1'b0, 1'b0, 1'b1);
    txn("coin12", 3'b100, 1'b0, 1'b0, 1'b0);
    txn("coin12_over", 3'b100, 1'b0, 1'b0, 1'b0);
    txn("coin_multi", 3'b011, 1'b0, 1'b0, 1'b0);
    txn("clear_b", 3'b000, 1'b0, 1'b0, 1'b1);
    txn("coin8", 3'b010, 1'b0, 1'b0, 1'b0);
    txn("vend_deny", 3'b000, 1'b1, 1'b0, 1'b0);
    txn("refund8", 3'b000, 1'b0, 1'b1, 1'b0);
    txn("refund_idle", 3'b000, 1'b0, 1'b1, 1'b0);
    txn("prio_clear", 3'b001, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset between edges, then a coin held across release.
    txn("coin12_pre_rst", 3'b100, 1'b0, 1'b0, 1'b0);
    @(posedge CLOCK_50);
    #2 RST_N = 1'b0;
    m_credit = 0; m_change = 0;
    #1 check_display("async_rst");
    check("async_rst_change", 32'(change), 32'(0));
    coin = 3'b001;
    repeat (2) @(negedge CLOCK_50);
    RST_N = 1'b1;
    n_rej = 0; n_any = 0;
    repeat (10) begin
      @(negedge CLOCK_50);
      n_any += int'(dispense) + int'(deny) + int'(reject) + int'(change_valid);
    end
    check("held_coin_pulses", 32'(n_any), 32'(0));
    check_display("held_coin");
    coin = '0;
    repeat (4) @(negedge CLOCK_50);
    $display("txn held_across_reset: credit=%0d", credit);
    txn("repress_coin4", 3'b001, 1'b0, 1'b0, 1'b0);

    txn("clear_c", 3'b000, 1'b0, 1'b0, 1'b1);
    txn("coin12_c", 3'b100, 1'b0, 1'b0, 1'b0);
    txn("coin8_to20", 3'b010, 1'b0, 1'b0, 1'b0);

    // Randomized transactions against the model.
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 9);
      cp = '0; v = 1'b0; r = 1'b0; c = 1'b0;
      if (kind <= 4) begin
        cp[$urandom_range(0, N_COIN - 1)] = 1'b1;
      end else if (kind == 5) begin
        cp = 3'b011 << $urandom_range(0, 1);
        if ($urandom_range(0, 1) == 1) cp = 3'b111;
      end else if (kind == 6) begin
        v = 1'b1;
      end else if (kind == 7) begin
        r = 1'b1;
      end else if (kind == 8) begin
        c = 1'b1;
      end else begin
        cp = 3'($urandom_range(0, 7));
        v  = 1'($urandom_range(0, 1));
        r  = 1'($urandom_range(0, 1));
        c  = 1'($urandom_range(0, 3) == 0);
        if (r && m_credit == 0) r = 1'b0;
      end
      txn($sformatf("rnd%0d", t), cp, v, r, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_credit_fsm.md
# vend_credit_fsm

Parametrised coin-credit controller for the DE-board vending exercises. It synchronises and edge-detects one-hot coin, vend, refund and clear buttons, and accumulates credit in integer units up to a configurable ceiling. It dispenses against a configurable price, returns change, and drives three active-low 7-segment digits showing the credit in decimal. It sits directly behind the board switches/keys and in front of the HEX/LEDG pins, with no slower clock domain.

## Interface
- UNIT, 4: value of the smallest coin; coin i is worth UNIT*(i+1).
- N_COIN, 3: number of coin inputs.
- CREDIT_W, 8: credit/change register width.
- MAX_CREDIT, 20: highest credit the block will hold.
- PRICE, 16: item price.
- Legal parameter combinations: MAX_CREDIT < 2**CREDIT_W, MAX_CREDIT ≤ 999, PRICE ≤ MAX_CREDIT. Any other combination is illegal and must fail elaboration.

Ports:
- CLOCK_50  in  1  sole clock.
- RST_N  in  1  reset, asynchronous, active-low.
- coin  in  N_COIN  raw coin buttons (level).
- vend  in  1  raw purchase button.
- refund  in  1  raw refund button.
- clear  in  1  raw clear button; zeroes the credit and returns no change.
- credit  out  CREDIT_W  current credit.
- dispense  out  1  one-cycle pulse when an item is released.
- deny  out  1  one-cycle pulse when vend is pressed with credit < PRICE.
- reject  out  1  one-cycle pulse when a coin would exceed MAX_CREDIT.
- change  out  CREDIT_W  change amount; valid only while change_valid is high.
- change_valid  out  1  one-cycle pulse.
- HEX2, HEX1, HEX0  out  [0:6] each  hundreds/tens/units digits, active-low, segment order a..g; digit 0 is encoded 7'b000_0001.

## Operation
- Every raw input passes through a 2-flop synchroniser, then a rising-edge detector.
- A coin event requires exactly one synchronised coin bit to rise while all other coin bits are low. Multi-bit coin patterns are ignored silently; they do not raise reject.
- Event priority when events occur in the same cycle: clear > refund > vend > coin. Lower-priority events in that cycle are dropped.
- States:
  - IDLE: credit = 0.
  - HOLD: credit > 0.
  - DISPENSE: one cycle.
  - RETURN: one cycle.
- State transitions:
  - coin, credit + value ≤ MAX_CREDIT: credit += value; go to HOLD.
  - coin, credit + value > MAX_CREDIT: reject pulse; credit unchanged.
  - vend, credit ≥ PRICE: go to DISPENSE (dispense=1, credit −= PRICE), then to HOLD or IDLE according to the remaining credit.
  - vend, credit < PRICE: deny pulse; no state change.
  - refund while in HOLD: go to RETURN (change = credit, change_valid = 1, credit = 0), then to IDLE.
  - refund while in IDLE: no action.
  - clear: credit = 0; go to IDLE; no pulses.
- Events arriving while in DISPENSE or RETURN are dropped; those states last one cycle only.
- Credit arithmetic uses CREDIT_W+1 bits internally so the overflow check never wraps.
- Display: credit is converted to three BCD digits, then to segment patterns, purely combinationally from the credit register.

## Timing
- Reset values: credit=0, change=0, all pulse outputs 0, state IDLE, synchroniser and edge registers 0. HEX2..HEX0 show 000.
- Latency: the first CLOCK_50 edge that samples a new high input level is edge n. The credit, state and pulse outputs update at edge n+3.
- All pulses are exactly one cycle wide and registered.
- change holds its value until the next RETURN or reset.
- RST_N asserted mid-operation clears all state immediately (asynchronously), including in-flight edges. Release of RST_N is synchronous to CLOCK_50.
- A button held high produces one event only; it must go low for ≥ 1 synchronised cycle to re-arm.

## Configuration
- AUTO_VEND_EN:
  - Defined: whenever the credit after a coin is ≥ PRICE, the block goes through DISPENSE and then RETURN automatically. It issues change = credit − PRICE (change_valid=1 even when change is 0), and credit ends at 0. The vend input is ignored.
  - Undefined: purchase happens only on a vend event, as described under Operation.

## Structure
- Package vend_pkg holds:
  - the state enum (IDLE, HOLD, DISPENSE, RETURN);
  - the 7-segment digit constants SEG0..SEG9;
  - a function returning the coin value for index i.
- Sub-module seg7_digit: 4-bit BCD in, [0:6] active-low segments out. It is instantiated three times.
- The synchroniser and edge detector stay inline.

## Test plan
- Reset: hold RST_N=0, release -> credit=0, HEX2/1/0 = 7'b000_0001, all pulses 0.
- Coins 4 then 12, then vend -> credit 4, then 16, HEX shows 0,1,6; then a dispense pulse and credit=0.
- Credit 12, insert coin 12 -> reject pulse, credit stays 12; coin[0] and coin[1] pressed together -> no change, no reject.
- Credit 8, vend -> deny pulse, credit 8; then refund -> change=8 with change_valid for 1 cycle, credit 0.
- Credit 12, RST_N pulsed low between clock edges -> credit 0 before the next edge; a coin held across reset release yields no event until it is re-pressed.
- With AUTO_VEND_EN: credit 12, insert coin 8 -> dispense, then change=4 with change_valid, credit 0.
